// File: rtl/rtc_time_counter.sv
// rtc_time_counter: time-of-day counter advanced by rising edges of the 10 Hz divider output.
// Define RTC_ALARM_EN to add a sticky hour:minute alarm.
module rtc_time_counter #(
    parameter int TENTHS_PER_SEC = 10,
    parameter int HOURS_PER_DAY  = 24
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_div_clk,
    input  logic       i_run,
    input  logic       i_set,
    input  logic [4:0] i_set_hour,
    input  logic [5:0] i_set_min,
    input  logic [5:0] i_set_sec,
`ifdef RTC_ALARM_EN
    input  logic [4:0] i_alarm_hour,
    input  logic [5:0] i_alarm_min,
    input  logic       i_alarm_set,
    input  logic       i_alarm_clr,
    output logic       o_alarm,
`endif
    output logic [3:0] o_tenth,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [4:0] o_hour,
    output logic       o_running,
    output logic       o_sec_pulse,
    output logic       o_day_pulse
);
    typedef enum logic {STOP, RUN} state_t;
    localparam logic [3:0] TENTH_MAX = 4'(TENTHS_PER_SEC - 1);
    localparam logic [4:0] HOUR_MAX  = 5'(HOURS_PER_DAY - 1);
    state_t     state;
    logic       div_d, tick, adv;
    logic       tenth_wrap, sec_wrap, min_wrap, hour_wrap;
    logic [3:0] tenth_n;
    logic [5:0] sec_n, min_n, load_min, load_sec;
    logic [4:0] hour_n, load_hour;
    // The divider shares i_clk, so its output is edge-detected without a synchronizer.
    always_comb begin
        tick       = i_div_clk & ~div_d;
        adv        = (state == RUN) & tick & ~i_set;
        tenth_wrap = o_tenth == TENTH_MAX;
        sec_wrap   = tenth_wrap & (o_sec == 6'd59);
        min_wrap   = sec_wrap & (o_min == 6'd59);
        hour_wrap  = min_wrap & (o_hour == HOUR_MAX);
        tenth_n    = tenth_wrap ? 4'd0 : o_tenth + 4'd1;
        sec_n      = sec_wrap ? 6'd0 : tenth_wrap ? o_sec + 6'd1 : o_sec;
        min_n      = min_wrap ? 6'd0 : sec_wrap ? o_min + 6'd1 : o_min;
        hour_n     = hour_wrap ? 5'd0 : min_wrap ? o_hour + 5'd1 : o_hour;
        load_hour  = ({1'b0, i_set_hour} < 6'(HOURS_PER_DAY)) ? i_set_hour : 5'd0;
        load_min   = (i_set_min < 6'd60) ? i_set_min : 6'd0;
        load_sec   = (i_set_sec < 6'd60) ? i_set_sec : 6'd0;
    end
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= STOP;
            div_d       <= 1'b1;
            o_running   <= 1'b0;
            o_sec_pulse <= 1'b0;
            o_day_pulse <= 1'b0;
            o_tenth     <= '0;
            o_sec       <= '0;
            o_min       <= '0;
            o_hour      <= '0;
        end else begin
            div_d       <= i_div_clk;
            state       <= i_run ? RUN : STOP;
            o_running   <= i_run;
            o_sec_pulse <= adv & tenth_wrap;
            o_day_pulse <= adv & hour_wrap;
            if (i_set) begin
                o_tenth <= '0;
                o_sec   <= load_sec;
                o_min   <= load_min;
                o_hour  <= load_hour;
            end else if (adv) begin
                o_tenth <= tenth_n;
                o_sec   <= sec_n;
                o_min   <= min_n;
                o_hour  <= hour_n;
            end
        end
    end
`ifdef RTC_ALARM_EN
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min;
    logic       alarm_hit;
    // Only counting across a minute boundary into the alarm time fires; loads never do.
    assign alarm_hit = adv & sec_wrap & (min_n == alarm_min) & (hour_n == alarm_hour);
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            alarm_hour <= '0;
            alarm_min  <= '0;
            o_alarm    <= 1'b0;
        end else begin
            if (i_alarm_set) begin
                alarm_hour <= i_alarm_hour;
                alarm_min  <= i_alarm_min;
            end
            o_alarm <= alarm_hit | (o_alarm & ~i_alarm_clr);
        end
    end
`endif
endmodule

// File: tb/tb_rtc_time_counter.sv
// tb_rtc_time_counter: randomized and directed checks of two counters (24 h and 12 h days)
// against a model that keeps time as a single count of tenths since midnight.
module tb_rtc_time_counter;
    localparam int unsigned DAY24 = 24 * 36000;
    localparam int unsigned DAY12 = 12 * 36000;
    logic clk = 0, rst = 0, div = 1, run = 0, set = 0;
    logic [4:0] sh = 0;
    logic [5:0] sm = 0, ss = 0;
    logic [3:0] a_t, b_t;
    logic [5:0] a_s, a_m, b_s, b_m;
    logic [4:0] a_h, b_h;
    logic a_run, a_sp, a_dp, b_run, b_sp, b_dp;
    int checks = 0, failures = 0;
    int unsigned m24 = 0, m12 = 0;
    bit m_div = 1, m_run = 0, e_sp24, e_dp24, e_sp12, e_dp12;
`ifdef RTC_ALARM_EN
    logic [4:0] al_h = 0;
    logic [5:0] al_m = 0;
    logic al_set = 0, al_clr = 0, a_al, b_al;
    int unsigned mal_h = 0, mal_m = 0;
    bit m_al = 0;
`endif

    always #5 clk = ~clk;

    rtc_time_counter #(.TENTHS_PER_SEC(10), .HOURS_PER_DAY(24)) dut24 (
        .i_clk(clk), .i_reset(rst), .i_div_clk(div), .i_run(run), .i_set(set),
        .i_set_hour(sh), .i_set_min(sm), .i_set_sec(ss),
`ifdef RTC_ALARM_EN
        .i_alarm_hour(al_h), .i_alarm_min(al_m), .i_alarm_set(al_set), .i_alarm_clr(al_clr), .o_alarm(a_al),
`endif
        .o_tenth(a_t), .o_sec(a_s), .o_min(a_m), .o_hour(a_h),
        .o_running(a_run), .o_sec_pulse(a_sp), .o_day_pulse(a_dp));

    rtc_time_counter #(.TENTHS_PER_SEC(10), .HOURS_PER_DAY(12)) dut12 (
        .i_clk(clk), .i_reset(rst), .i_div_clk(div), .i_run(run), .i_set(set),
        .i_set_hour(sh), .i_set_min(sm), .i_set_sec(ss),
`ifdef RTC_ALARM_EN
        .i_alarm_hour(al_h), .i_alarm_min(al_m), .i_alarm_set(al_set), .i_alarm_clr(al_clr), .o_alarm(b_al),
`endif
        .o_tenth(b_t), .o_sec(b_s), .o_min(b_m), .o_hour(b_h),
        .o_running(b_run), .o_sec_pulse(b_sp), .o_day_pulse(b_dp));

    function automatic logic [20:0] hmst(int unsigned tot);
        return {5'(tot / 36000), 6'((tot / 600) % 60), 6'((tot / 10) % 60), 4'(tot % 10)};
    endfunction

    function automatic int unsigned load(int unsigned hpd);
        int unsigned h, m, s;
        h = (sh >= hpd) ? 0 : sh;
        m = (sm >= 60) ? 0 : sm;
        s = (ss >= 60) ? 0 : ss;
        return ((h * 60 + m) * 60 + s) * 10;
    endfunction

    function automatic logic [47:0] obs();
        return {a_h, a_m, a_s, a_t, a_sp, a_dp, a_run, b_h, b_m, b_s, b_t, b_sp, b_dp, b_run};
    endfunction

    function automatic logic [47:0] expv();
        return {hmst(m24), e_sp24, e_dp24, m_run, hmst(m12), e_sp12, e_dp12, m_run};
    endfunction

    task automatic model_reset();
        m24 = 0; m12 = 0; m_div = 1; m_run = 0;
        e_sp24 = 0; e_dp24 = 0; e_sp12 = 0; e_dp12 = 0;
`ifdef RTC_ALARM_EN
        mal_h = 0; mal_m = 0; m_al = 0;
`endif
    endtask

    // One clock: predict the effect of the current inputs, then sample 1 time unit after the edge.
    task automatic cyc();
        bit tick, trig;
        tick = div && !m_div;
        trig = 0;
        e_sp24 = 0; e_dp24 = 0; e_sp12 = 0; e_dp12 = 0;
        if (set) begin
            m24 = load(24);
            m12 = load(12);
        end else if (m_run && tick) begin
            m24 = (m24 + 1) % DAY24;
            m12 = (m12 + 1) % DAY12;
            e_sp24 = (m24 % 10) == 0; e_dp24 = m24 == 0;
            e_sp12 = (m12 % 10) == 0; e_dp12 = m12 == 0;
`ifdef RTC_ALARM_EN
            trig = (m24 % 600) == 0 && (m24 / 600) == mal_h * 60 + mal_m;
`endif
        end
`ifdef RTC_ALARM_EN
        m_al = trig || (m_al && !al_clr);
        if (al_set) begin mal_h = al_h; mal_m = al_m; end
`endif
        m_div = div; m_run = run;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        div = 1; run = 0;
        #1 rst = 1;
        model_reset();
        #2;
        if (obs() !== 48'h0) begin failures++; $display("FAIL reset_state got=%h exp=0", obs()); end
        checks++;
        @(posedge clk); #1;
        rst = 0; run = 1;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (obs() !== expv()) begin failures++; $display("FAIL idle_high_div i=%0d got=%h exp=%h", i, obs(), expv()); end
            checks++;
        end
        if ({a_h, a_m, a_s, a_t, a_run} !== {21'h0, 1'b1}) begin failures++; $display("FAIL idle_const got=%h exp=1", {a_h, a_m, a_s, a_t, a_run}); end
        checks++;
    endtask

    task automatic test_count();
        int pulses = 0;
        div = 0; cyc();
        for (int i = 0; i < 10; i++) begin
            div = 1; cyc();
            pulses += a_sp;
            if (obs() !== expv()) begin failures++; $display("FAIL count_hi i=%0d got=%h exp=%h", i, obs(), expv()); end
            checks++;
            div = 0; cyc();
            pulses += a_sp;
            if (obs() !== expv()) begin failures++; $display("FAIL count_lo i=%0d got=%h exp=%h", i, obs(), expv()); end
            checks++;
        end
        if ({a_s, a_t} !== {6'd1, 4'd0} || pulses != 1) begin
            failures++; $display("FAIL count_sec got=%0d.%0d pulses=%0d exp=1.0 pulses=1", a_s, a_t, pulses);
        end
        checks++;
    endtask

    task automatic ten_edges(input string name, input bit last_24);
        for (int i = 0; i < 10; i++) begin
            div = 1; cyc();
            if (obs() !== expv()) begin failures++; $display("FAIL %s_hi i=%0d got=%h exp=%h", name, i, obs(), expv()); end
            checks++;
            if (i == 9 && last_24 && {a_h, a_m, a_s, a_t, a_sp, a_dp} !== 23'b11) begin
                failures++; $display("FAIL %s_day24 got=%h exp=3", name, {a_h, a_m, a_s, a_t, a_sp, a_dp});
            end
            if (i == 9 && !last_24 && {b_h, b_m, b_s, b_t, b_sp, b_dp, a_h, a_dp} !== {23'b11, 5'd12, 1'b0}) begin
                failures++; $display("FAIL %s_day12 got=%h exp=%h", name, {b_h, b_m, b_s, b_t, b_sp, b_dp, a_h, a_dp}, {23'b11, 5'd12, 1'b0});
            end
            if (i == 9) checks++;
            div = 0; cyc();
            if (obs() !== expv()) begin failures++; $display("FAIL %s_lo i=%0d got=%h exp=%h", name, i, obs(), expv()); end
            checks++;
        end
    endtask

    task automatic test_wrap();
        set = 1; sh = 23; sm = 59; ss = 59; cyc(); set = 0;
        ten_edges("wrap24", 1);
        set = 1; sh = 11; sm = 59; ss = 59; cyc(); set = 0;
        ten_edges("wrap12", 0);
    endtask

    task automatic test_set();
        div = 1; set = 1; sh = 12; sm = 34; ss = 56; cyc(); set = 0;
        if ({a_h, a_m, a_s, a_t, a_sp, a_dp} !== {5'd12, 6'd34, 6'd56, 4'd0, 2'b00} || obs() !== expv()) begin
            failures++; $display("FAIL set_tick got=%h exp=%h", obs(), expv());
        end
        checks++;
        div = 0; cyc();
        set = 1; sh = 25; sm = 61; ss = 30; cyc(); set = 0;
        if ({a_h, a_m, a_s, a_t} !== {5'd0, 6'd0, 6'd30, 4'd0} || obs() !== expv()) begin
            failures++; $display("FAIL set_clamp got=%h exp=%h", obs(), expv());
        end
        checks++;
    endtask

    task automatic test_hold();
        logic [3:0] t0;
        run = 0; cyc();
        for (int i = 0; i < 5; i++) begin
            div = 1; cyc(); div = 0; cyc();
            if (obs() !== expv()) begin failures++; $display("FAIL hold i=%0d got=%h exp=%h", i, obs(), expv()); end
            checks++;
        end
        run = 1; cyc();
        t0 = a_t;
        div = 1; run = 0; cyc();
        if (obs() !== expv() || a_t !== t0 + 4'd1) begin failures++; $display("FAIL stop_tick got=%h exp=%h", obs(), expv()); end
        checks++;
        div = 0; cyc(); div = 1; cyc(); div = 0; cyc();
        if (obs() !== expv() || a_t !== t0 + 4'd1) begin failures++; $display("FAIL stopped got=%h exp=%h", obs(), expv()); end
        checks++;
    endtask

    task automatic test_async_reset();
        run = 1; cyc();
        for (int i = 0; i < 7; i++) begin div = 1; cyc(); div = 0; cyc(); end
        #2 rst = 1;
        model_reset();
        #1;
        if (obs() !== 48'h0) begin failures++; $display("FAIL async_reset got=%h exp=0", obs()); end
        checks++;
        @(posedge clk); #1;
        rst = 0; div = 1;
    endtask

`ifdef RTC_ALARM_EN
    task automatic alarm_run(input bit clr_last);
        set = 1; sh = 0; sm = 0; ss = 59; cyc(); set = 0;
        for (int i = 0; i < 10; i++) begin
            div = 1; al_clr = clr_last && i == 9; cyc(); al_clr = 0;
            if (a_al !== m_al || obs() !== expv()) begin failures++; $display("FAIL alarm_edge i=%0d got=%b exp=%b", i, a_al, m_al); end
            checks++;
            div = 0; cyc();
        end
        if (a_al !== 1'b1) begin failures++; $display("FAIL alarm_high got=%b exp=1", a_al); end
        checks++;
    endtask

    task automatic test_alarm();
        run = 1; div = 0; cyc();
        al_h = 0; al_m = 1; al_set = 1; cyc(); al_set = 0;
        alarm_run(0);
        alarm_run(1);
        al_clr = 1; cyc(); al_clr = 0;
        if (a_al !== 1'b0 || m_al) begin failures++; $display("FAIL alarm_clr got=%b exp=0", a_al); end
        checks++;
        set = 1; sh = 0; sm = 1; ss = 0; cyc(); set = 0; cyc();
        if (a_al !== 1'b0) begin failures++; $display("FAIL alarm_by_set got=%b exp=0", a_al); end
        checks++;
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 2) == 0) div = ~div;
            if ($urandom_range(0, 29) == 0) run = ~run;
            set = $urandom_range(0, 149) == 0;
            if ($urandom_range(0, 1) == 0) begin sh = 5'($urandom); sm = 6'($urandom); ss = 6'($urandom); end
            else begin sh = $urandom_range(0, 1) ? 5'd23 : 5'd11; sm = 59; ss = 6'($urandom_range(57, 59)); end
`ifdef RTC_ALARM_EN
            al_set = $urandom_range(0, 299) == 0; al_clr = $urandom_range(0, 99) == 0;
            al_h = $urandom_range(0, 1) ? 5'd0 : 5'd12; al_m = 0;
`endif
            cyc();
            if (obs() !== expv()) begin failures++; $display("FAIL random i=%0d got=%h exp=%h", i, obs(), expv()); end
`ifdef RTC_ALARM_EN
            if (a_al !== m_al) begin failures++; $display("FAIL random_alarm i=%0d got=%b exp=%b", i, a_al, m_al); end
`endif
            checks++;
        end
        set = 0;
    endtask

    initial begin
        test_reset();
        test_count();
        test_wrap();
        test_set();
        test_hold();
        test_async_reset();
`ifdef RTC_ALARM_EN
        test_alarm();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
